sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Parametrised successive-approximation ADC controller for the external-comparator / PWM-DAC front end. It replaces the fixed 8-bit clock-divided binary search with three additions:
- configurable resolution;
- a per-bit settle counter on CLOCK_50;
- multi-channel scanning through an external analog mux.
It also adds a start/busy/valid handshake, an optional continuous mode, and integrates the PWM DAC that drives the comparator reference.

Parameters:
WIDTH, 8, conversion resolution in bits; also the PWM DAC resolution (PWM period = 2^WIDTH clocks).
SETTLE_CYCLES, 4096, clocks waited after each DAC/mux change before the comparator is sampled; must be >= 3.
NUM_CH, 4, number of analog mux channels scanned; >= 1.
CH_W, 2, width of channel index; must satisfy 2^CH_W >= NUM_CH.

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset.
start  in  1  request one conversion; sampled only in IDLE.
continuous  in  1  1 = start next conversion (next channel) immediately after each result.
compare  in  1  asynchronous external comparator; 1 = analog input >= DAC voltage.
ch_sel_out  out  CH_W  analog mux select for the conversion in progress.
dac_code  out  WIDTH  current trial code fed to the PWM DAC.
pwm_out  out  1  PWM DAC output to the RC filter.
result  out  WIDTH  last completed conversion value.
result_ch  out  CH_W  channel that result belongs to.
result_valid  out  1  one-cycle pulse when result/result_ch update.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clock edge) forces all outputs to 0: dac_code, result, result_ch, result_valid, busy, ch_sel_out, pwm_out. It also clears the state to IDLE, the settle counter, the bit index and the synchronizer.
- compare passes through a 2-flop synchronizer (compare_s). Only compare_s is used.
- Each settle state runs a down-counter loaded with SETTLE_CYCLES-1 and exits when it reaches 0. Each settle state therefore lasts exactly SETTLE_CYCLES cycles.
- IDLE:
  - busy=0; dac_code holds its last value.
  - start=1 -> MUX_SETTLE.
  - On entry to MUX_SETTLE: ch_sel_out <= current channel; dac_code <= 1 << (WIDTH-1); bit_idx <= WIDTH-1.
- MUX_SETTLE: wait SETTLE_CYCLES -> BIT_SETTLE. Executed on every conversion, including NUM_CH=1, so latency is uniform.
- BIT_SETTLE: wait SETTLE_CYCLES -> DECIDE.
- DECIDE (1 cycle):
  - If compare_s=0, clear dac_code[bit_idx]; otherwise keep it.
  - If bit_idx>0: set dac_code[bit_idx-1], decrement bit_idx, go to BIT_SETTLE.
  - If bit_idx=0: result <= final code, result_ch <= ch_sel_out, result_valid <= 1, go to DONE.
- DONE (1 cycle, result_valid=1):
  - Channel advances: NUM_CH-1 wraps to 0.
  - If continuous=1: next state is MUX_SETTLE, with the same entry actions as from IDLE. busy stays high.
  - Otherwise: next state is IDLE. busy goes low on the following cycle.
- Latency: result_valid is high SETTLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) clocks after the edge that accepts start. Continuous-mode result period = that value + 1.
- result_valid is high for exactly one cycle per conversion; result is stable between pulses.
- Boundaries:
  - start while busy: ignored.
  - continuous deasserted mid-conversion: current conversion completes, then IDLE.
  - compare stuck 1 -> result all ones; compare stuck 0 -> result 0.
  - Reset mid-conversion: aborts with no result_valid, and the channel returns to 0.
- pwm_dac:
  - Free-running WIDTH-bit counter.
  - Duty is latched from dac_code when the counter wraps to 0.
  - pwm_out = (cnt < duty_latched), registered.
  - Duty 0 -> constantly 0; duty 2^WIDTH-1 -> high 2^WIDTH-1 of every 2^WIDTH cycles.
  - A dac_code change takes effect only at the next period boundary.

Decomposition:
- Shared package/header sar_adc_pkg: state encodings (IDLE, MUX_SETTLE, BIT_SETTLE, DECIDE, DONE) and the width-check constants.
- One sub-module, pwm_dac #(WIDTH): counter, duty latch, output register. It uses the same CLOCK_50/rst convention.
- Synchronizer, FSM, settle counter and channel counter stay in sar_adc_ctrl.

Test Plan:
Test configuration is WIDTH=8, SETTLE_CYCLES=4, NUM_CH=4. The comparator model is compare = (vin[ch_sel_out] >= dac_code).
1. Hold rst=0 for 3 cycles with start=1 and compare=1 -> all outputs 0 and busy 0. Releasing rst with start=0 -> remains IDLE.
2. ch0 vin=173, single start pulse -> busy next cycle; result_valid high exactly 44 clocks after the accepting edge, for 1 cycle; result=173, result_ch=0; busy low 1 cycle later. Also vin=0 -> result 0 and vin=255 -> result 255.
3. continuous=1, vin={10,100,200,255} -> pulses 45 cycles apart with result_ch 0,1,2,3,0 and results 10,100,200,255,10. ch_sel_out changes only at MUX_SETTLE entry.
4. start pulses while busy -> no extra conversion. Drop continuous mid-conversion -> that conversion completes, then busy=0 and no further pulses.
5. Drive dac_code=64 (converted value held in IDLE) -> pwm_out high 64 of every 256 cycles. Code 0 -> never high. A code change mid-period does not alter the current period.
6. Assert rst=0 during BIT_SETTLE of bit 5 -> next cycle all outputs 0 and no result_valid. A following start converts ch0 with correct result and 44-cycle latency.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding and
// the parameter sanity limits checked at elaboration.
package sar_adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX_SETTLE,
    S_BIT_SETTLE,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam int MIN_SETTLE_CYCLES = 3;
  localparam int MIN_NUM_CH        = 1;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_pwm_dac.sv
// PWM DAC: free-running counter, duty latched at each period boundary,
// registered compare output driving the external RC filter.
module pwm_dac #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  // Duty only changes when the counter wraps, so a period is never split.
  always_comb begin
    cnt_d  = cnt_q + WIDTH'(1);
    duty_d = (cnt_d == '0) ? duty_in : duty_q;
    pwm_d  = (cnt_q < duty_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller with per-bit settle time,
// multi-channel mux scanning and an integrated PWM reference DAC.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4096,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             compare,
  output logic [CH_W-1:0]  ch_sel_out,
  output logic [WIDTH-1:0] dac_code,
  output logic             pwm_out,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             result_valid,
  output logic             busy
);

  localparam int CNT_W = idx_width(SETTLE_CYCLES);
  localparam int BIT_W = idx_width(WIDTH);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] TOP_BIT     = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MID_CODE    = WIDTH'(1) << (WIDTH - 1);

  if (SETTLE_CYCLES < MIN_SETTLE_CYCLES || NUM_CH < MIN_NUM_CH ||
      (1 << CH_W) < NUM_CH) begin : g_bad_cfg
    $error("sar_adc_ctrl: illegal parameter combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             meta_q, cmp_s_q;

  logic [WIDTH-1:0] code;
  logic [CH_W-1:0]  next_ch;
  logic [CH_W-1:0]  launch_ch;
  logic             launch;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    dac_d       = dac_q;
    ch_d        = ch_q;
    ch_sel_d    = ch_sel_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;
    code        = dac_q;
    next_ch     = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
    launch      = 1'b0;
    launch_ch   = ch_q;

    case (state_q)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end
      S_MUX_SETTLE, S_BIT_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = (state_q == S_MUX_SETTLE) ? S_BIT_SETTLE : S_DECIDE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DECIDE: begin
        if (!cmp_s_q) code[bit_q] = 1'b0;
        if (bit_q != '0) begin
          code[bit_q - BIT_W'(1)] = 1'b1;
          bit_d   = bit_q - BIT_W'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = S_BIT_SETTLE;
        end else begin
          result_d    = code;
          result_ch_d = ch_sel_q;
          valid_d     = 1'b1;
          state_d     = S_DONE;
        end
        dac_d = code;
      end
      S_DONE: begin
        ch_d      = next_ch;
        launch_ch = next_ch;
        if (continuous) launch = 1'b1;
        else            state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Starting from IDLE and chaining in continuous mode share one entry path.
    if (launch) begin
      state_d  = S_MUX_SETTLE;
      cnt_d    = SETTLE_LOAD;
      bit_d    = TOP_BIT;
      dac_d    = MID_CODE;
      ch_sel_d = launch_ch;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      dac_q       <= '0;
      ch_q        <= '0;
      ch_sel_q    <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      meta_q      <= 1'b0;
      cmp_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      dac_q       <= dac_d;
      ch_q        <= ch_d;
      ch_sel_q    <= ch_sel_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      meta_q      <= compare;
      cmp_s_q     <= meta_q;
    end
  end

  pwm_dac #(.WIDTH(WIDTH)) u_pwm (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .duty_in  (dac_q),
    .pwm_out  (pwm_out)
  );

  assign ch_sel_out   = ch_sel_q;
  assign dac_code     = dac_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl (WIDTH=8, SETTLE_CYCLES=4, NUM_CH=4) with
// an ideal comparator model: compare = vin[ch_sel_out] >= dac_code.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b1;
  logic       continuous = 1'b0;
  logic       compare;
  logic [1:0] ch_sel_out;
  logic [7:0] dac_code;
  logic       pwm_out;
  logic [7:0] result;
  logic [1:0] result_ch;
  logic       result_valid;
  logic       busy;

  logic [7:0] vin [0:3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] vin;
    logic [1:0] ch;
    logic [7:0] expRes;
  } vec_t;

  vec_t vecs [0:2];

  sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(4), .NUM_CH(4), .CH_W(2)) dut (
    .CLOCK_50     (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .compare      (compare),
    .ch_sel_out   (ch_sel_out),
    .dac_code     (dac_code),
    .pwm_out      (pwm_out),
    .result       (result),
    .result_ch    (result_ch),
    .result_valid (result_valid),
    .busy         (busy)
  );

  assign compare = (vin[ch_sel_out] >= dac_code);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive a one-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic cont);
    @(negedge clk);
    continuous = cont;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic setAllVin(input logic [7:0] v);
    for (int i = 0; i < 4; i++) vin[i] = v;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dac"}, dac_code, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_result_ch"}, result_ch, 0);
    checkOutput({tag, "_valid"}, result_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ch_sel"}, ch_sel_out, 0);
    checkOutput({tag, "_pwm"}, pwm_out, 0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    setAllVin(8'd255);
    repeat (3) @(negedge clk);
    checkAllZero(tag);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_valid"}, result_valid, 0);
  endtask

  // Single conversion on channel ch with latency, result and handshake checks.
  task automatic runConversion(input string name, input logic [7:0] v,
                               input logic [1:0] ch, input logic [7:0] expRes);
    int tAcc;
    setAllVin(8'h99);
    vin[ch] = v;
    applyStimulus(1'b0);
    tAcc = cyc;
    checkOutput({name, "_busy_rise"}, busy, 1);
    while (!result_valid && (cyc - tAcc) < 200) @(negedge clk);
    checkOutput({name, "_latency"}, cyc - tAcc, 44);
    checkOutput({name, "_result"}, result, expRes);
    checkOutput({name, "_result_ch"}, result_ch, ch);
    @(negedge clk);
    checkOutput({name, "_valid_pulse"}, result_valid, 0);
    checkOutput({name, "_busy_fall"}, busy, 0);
  endtask

  task automatic countPwmHigh(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  initial begin
    int prevT, tAcc, changes, badChanges, pulses, highs, n;
    int periodHigh [0:1];
    logic [1:0] prevCh;
    logic prevValid, prevP, found;
    logic [7:0] contExp [0:4];

    vecs[0] = '{vin: 8'd173, ch: 2'd0, expRes: 8'd173};
    vecs[1] = '{vin: 8'd0,   ch: 2'd1, expRes: 8'd0};
    vecs[2] = '{vin: 8'd255, ch: 2'd2, expRes: 8'd255};
    contExp[0] = 8'd10;  contExp[1] = 8'd100; contExp[2] = 8'd200;
    contExp[3] = 8'd255; contExp[4] = 8'd10;
    setAllVin(8'd255);

    // Reset behaviour and idle after release.
    doReset("reset");

    // Single conversions, channel advances after each one.
    for (int i = 0; i < 3; i++)
      runConversion($sformatf("single%0d", i), vecs[i].vin, vecs[i].ch, vecs[i].expRes);

    // Continuous scan from channel 0.
    doReset("reset2");
    vin[0] = 8'd10; vin[1] = 8'd100; vin[2] = 8'd200; vin[3] = 8'd255;
    applyStimulus(1'b1);
    tAcc = cyc;
    prevT = tAcc;
    changes = 0;
    badChanges = 0;
    prevCh = ch_sel_out;
    prevValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (ch_sel_out !== prevCh) begin
          changes++;
          if (!prevValid) badChanges++;
        end
        prevCh = ch_sel_out;
        prevValid = result_valid;
      end while (!result_valid && n < 200);
      checkOutput($sformatf("cont_period%0d", k), cyc - prevT, (k == 0) ? 44 : 45);
      checkOutput($sformatf("cont_result%0d", k), result, contExp[k]);
      checkOutput($sformatf("cont_ch%0d", k), result_ch, k % 4);
      prevT = cyc;
    end
    checkOutput("cont_ch_changes", changes, 4);
    checkOutput("cont_ch_change_timing", badChanges, 0);

    // Start while busy is ignored; dropping continuous finishes the current conversion.
    repeat (10) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    continuous = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!result_valid && (cyc - prevT) < 200) @(negedge clk);
    checkOutput("drop_cont_period", cyc - prevT, 45);
    checkOutput("drop_cont_result", result, 100);
    checkOutput("drop_cont_ch", result_ch, 1);
    @(negedge clk);
    checkOutput("drop_cont_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (result_valid || busy) pulses++;
    end
    checkOutput("drop_cont_no_more", pulses, 0);

    // PWM with the converted code held in IDLE.
    runConversion("pwm64", 8'd64, 2'd2, 8'd64);
    repeat (600) @(negedge clk);
    countPwmHigh(256, highs);
    checkOutput("pwm64_highs", highs, 64);

    // Code change mid-period only takes effect at the next boundary.
    setAllVin(8'd200);
    prevP = pwm_out;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      found = pwm_out && !prevP;
      prevP = pwm_out;
    end while (!found && n < 600);
    checkOutput("pwm_edge_found", found, 1);
    periodHigh[0] = pwm_out ? 1 : 0;
    periodHigh[1] = 0;
    for (int i = 1; i < 512; i++) begin
      if (i == 100) start = 1'b1;
      if (i == 101) start = 1'b0;
      @(negedge clk);
      if (pwm_out) periodHigh[i / 256]++;
    end
    checkOutput("pwm_midchange_cur", periodHigh[0], 64);
    checkOutput("pwm_midchange_next", periodHigh[1], 200);
    checkOutput("pwm_midchange_result", result, 200);
    checkOutput("pwm_midchange_ch", result_ch, 3);

    runConversion("pwm0", 8'd0, 2'd0, 8'd0);
    repeat (600) @(negedge clk);
    countPwmHigh(256, highs);
    checkOutput("pwm0_highs", highs, 0);

    // Reset during BIT_SETTLE of bit 5 on channel 1, then a clean conversion.
    setAllVin(8'h99);
    applyStimulus(1'b0);
    tAcc = cyc;
    while ((cyc - tAcc) < 16) @(negedge clk);
    checkOutput("abort_busy_before", busy, 1);
    checkOutput("abort_ch_before", ch_sel_out, 1);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_valid", result_valid, 0);
    runConversion("after_abort", 8'd77, 2'd0, 8'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
